alu_multicycle: RTL and testbench

Parametrised, registered successor to the single-cycle MIPS ALU. It executes the existing logic, arithmetic, shift, compare and branch-test operations with a one-cycle registered latency. It adds iterative signed/unsigned multiply and divide that write HI/LO registers, and true signed overflow detection. It sits in the EX stage; the pipeline controller stalls on `busy`.

---
 rtl/alu_multicycle.sv | 212 +++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: one-cycle logic/arith/shift/compare/branch ops plus
// optional iterative MULT/MULTU/DIV/DIVU into hi/lo, enabled by `define ALU_MULDIV_EN.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       aluctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shft,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  function automatic logic [WIDTH-1:0] bit2w(input logic b);
    return {{(WIDTH-1){1'b0}}, b};
  endfunction

  logic signed [WIDTH-1:0] as_p0, bs_p0;
  logic        [WIDTH-1:0] sum_p0, dif_p0, res_p0;
  logic                    ovf_p0;
  logic                    sc_issue;

  assign as_p0  = A;
  assign bs_p0  = B;
  assign sum_p0 = A + B;
  assign dif_p0 = A - B;
  assign zero   = (y == '0);

  // ---- stage 0: single-cycle result, registered into y/ovflow below
  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    case (aluctr)
      5'b00000: begin
        res_p0 = sum_p0;
        ovf_p0 = add_ovf(A[WIDTH-1], B[WIDTH-1], sum_p0[WIDTH-1]);
      end
      5'b00001: begin
        res_p0 = dif_p0;
        ovf_p0 = sub_ovf(A[WIDTH-1], B[WIDTH-1], dif_p0[WIDTH-1]);
      end
      5'b00010: res_p0 = bit2w(as_p0 < bs_p0);
      5'b01000: res_p0 = bit2w(A < B);
      5'b00011: res_p0 = A & B;
      5'b00100: res_p0 = ~(A | B);
      5'b00101: res_p0 = A | B;
      5'b00110: res_p0 = A ^ B;
      5'b00111: res_p0 = B << shft;
      5'b01001: res_p0 = bs_p0 >>> shft;
      5'b01010: res_p0 = B >> shft;
      5'b10000: res_p0 = bit2w(A[WIDTH-1]);
      5'b10001: res_p0 = bit2w(A[WIDTH-1] || (A == '0));
      5'b10010: res_p0 = bit2w(!A[WIDTH-1] && (A != '0));
      5'b10011: res_p0 = bit2w(!A[WIDTH-1]);
      default:  res_p0 = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t               state, state_nx;
  logic [SHW-1:0]       cnt;
  logic [2*WIDTH:0]     acc, mul_nx, div_nx;
  logic [WIDTH-1:0]     mb;
  logic [WIDTH:0]       madd, dtry;
  logic                 neg_q, neg_r, is_div, dz_pend;
  logic                 can_issue, is_md, md_issue, dz_issue, sgn_op;

  // FIX is the write-back cycle, so a new op may be issued on its closing edge.
  assign can_issue = (state == IDLE) || (state == FIX);
  assign is_md     = (aluctr[4:2] == 3'b110);
  assign sgn_op    = !aluctr[0];
  assign md_issue  = start && can_issue && is_md;
  assign dz_issue  = md_issue && aluctr[1] && (B == '0);
  assign sc_issue  = start && can_issue && !is_md;
  assign busy      = (state != IDLE);

  // acc = {remainder/partial product (WIDTH+1), quotient/multiplier (WIDTH)}
  assign madd   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mb} : '0);
  assign mul_nx = {1'b0, madd, acc[WIDTH-1:1]};
  assign dtry   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
  assign div_nx = dtry[WIDTH] ? {acc[2*WIDTH-1:0], 1'b0}
                              : {dtry, acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIX: begin
        state_nx = IDLE;
        if (md_issue) state_nx = dz_issue ? FIX : (aluctr[1] ? DIV : MUL);
      end
      MUL, DIV: if (cnt == SHW'(WIDTH-1)) state_nx = FIX;
      default:  state_nx = IDLE;
    endcase
  end

  // ---- stage 1: operand latch (magnitudes) and one iteration step per cycle
  always_ff @(posedge clk) begin
    if (md_issue) begin
      acc     <= {{(WIDTH+1){1'b0}}, dz_issue ? A : mag(A, sgn_op)};
      mb      <= mag(B, sgn_op);
      neg_q   <= sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
      neg_r   <= sgn_op && A[WIDTH-1];
      is_div  <= aluctr[1];
      dz_pend <= dz_issue;
    end else if (state == MUL) begin
      acc <= mul_nx;
    end else if (state == DIV) begin
      acc <= div_nx;
    end
  end

  // ---- stage 2: sign correction and hi/lo write-back in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      dz  <= 1'b0;
    end else begin
      cnt <= (state == MUL || state == DIV) ? cnt + SHW'(1) : '0;
      dz  <= (state == FIX) && dz_pend;
      if (state == FIX) begin
        if (dz_pend) begin
          hi <= acc[WIDTH-1:0];
          lo <= '1;
        end else if (is_div) begin
          hi <= fix_sign(acc[2*WIDTH-1:WIDTH], neg_r);
          lo <= fix_sign(acc[WIDTH-1:0], neg_q);
        end else begin
          {hi, lo} <= fix_sign2(acc[2*WIDTH-1:0], neg_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= '0;
      ovflow <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= sc_issue || (state == FIX);
      if (sc_issue) begin
        y      <= res_p0;
        ovflow <= ovf_p0;
      end
    end
  end

`else

  assign sc_issue = start;
  assign busy     = 1'b0;
  assign dz       = 1'b0;
  assign hi       = '0;
  assign lo       = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y      <= '0;
      ovflow <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= sc_issue;
      if (sc_issue) begin
        y      <= res_p0;
        ovflow <= ovf_p0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations; follows ALU_MULDIV_EN.
module tb_alu_multicycle;
  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk, rst, start;
  logic [4:0]   aluctr, shft;
  logic [W-1:0] A, B, y, hi, lo;
  logic         zero, ovflow, busy, done, dz;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .aluctr(aluctr), .A(A), .B(B),
    .shft(shft), .y(y), .zero(zero), .ovflow(ovflow), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic predict(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, output logic [W-1:0] ry, output logic rov,
                         output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                         output logic rdz, output bit multi);
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ry = '0; rov = 1'b0; rhi = '0; rlo = '0; rdz = 1'b0; multi = 1'b0;
    if (MD_EN && op[4:2] == 3'b110) begin
      multi = 1'b1;
      case (op[1:0])
        2'd0: begin r = sa * sb; {rhi, rlo} = r; end
        2'd1: begin ur = ua * ub; {rhi, rlo} = ur; end
        2'd2: if (b == 0) begin rdz = 1'b1; rlo = '1; rhi = a; end
              else begin r = sa / sb; rlo = r[31:0]; r = sa % sb; rhi = r[31:0]; end
        default: if (b == 0) begin rdz = 1'b1; rlo = '1; rhi = a; end
              else begin ur = ua / ub; rlo = ur[31:0]; ur = ua % ub; rhi = ur[31:0]; end
      endcase
    end else begin
      case (op)
        5'b00000: begin r = sa + sb; ry = r[31:0]; rov = (r != longint'($signed(ry))); end
        5'b00001: begin r = sa - sb; ry = r[31:0]; rov = (r != longint'($signed(ry))); end
        5'b00010: ry = (sa < sb) ? 32'd1 : 32'd0;
        5'b01000: ry = (ua < ub) ? 32'd1 : 32'd0;
        5'b00011: ry = a & b;
        5'b00100: ry = ~(a | b);
        5'b00101: ry = a | b;
        5'b00110: ry = a ^ b;
        5'b00111: ry = b << sh;
        5'b01001: begin r = sb >>> sh; ry = r[31:0]; end
        5'b01010: ry = b >> sh;
        5'b10000: ry = (sa < 0)  ? 32'd1 : 32'd0;
        5'b10001: ry = (sa <= 0) ? 32'd1 : 32'd0;
        5'b10010: ry = (sa > 0)  ? 32'd1 : 32'd0;
        5'b10011: ry = (sa >= 0) ? 32'd1 : 32'd0;
        default:  ry = '0;
      endcase
    end
  endtask

  logic [W-1:0] e_y, e_hi, e_lo, p_hi, p_lo;
  logic         e_ovf, e_busy, e_done, e_dz, p_dz;
  int           rem;

  initial begin
    logic [W-1:0] ty, thi, tlo;
    logic         tov, tdz, was_busy;
    bit           tm;
    e_y = '0; e_hi = '0; e_lo = '0; e_ovf = 1'b0; e_busy = 1'b0;
    e_done = 1'b0; e_dz = 1'b0; rem = 0; p_hi = '0; p_lo = '0; p_dz = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e_y = '0; e_hi = '0; e_lo = '0; e_ovf = 1'b0; e_busy = 1'b0;
        e_done = 1'b0; e_dz = 1'b0; rem = 0;
      end else begin
        was_busy = e_busy;
        e_done = 1'b0;
        e_dz = 1'b0;
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            e_hi = p_hi; e_lo = p_lo; e_dz = p_dz; e_done = 1'b1; e_busy = 1'b0;
          end
        end
        if (start && !was_busy) begin
          predict(aluctr, A, B, shft, ty, tov, thi, tlo, tdz, tm);
          if (tm) begin
            p_hi = thi; p_lo = tlo; p_dz = tdz; e_busy = 1'b1;
            rem = tdz ? 1 : W + 1;
          end else begin
            e_y = ty; e_ovf = tov; e_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("y", y, e_y);
      chk("zero", zero, e_y == '0);
      chk("ovflow", ovflow, e_ovf);
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("dz", dz, e_dz);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    aluctr = op; A = a; B = b; shft = sh; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: actual timeout required done pulse");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; aluctr = '0; A = '0; B = '0; shft = '0;
    repeat (2) tick();
    chk("rst_y", y, 0);       chk("rst_zero", zero, 1);
    chk("rst_hi", hi, 0);     chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);     chk("rst_ovf", ovflow, 0);
    rst = 1'b0;
    tick();

    issue(5'b00000, 32'h7FFFFFFF, 32'h1, 0);
    chk("add_y", y, 64'h80000000); chk("add_ovf", ovflow, 1); chk("add_done", done, 1);
    tick();
    chk("add_done_drop", done, 0); chk("add_y_hold", y, 64'h80000000);
    issue(5'b00001, 32'd5, 32'd5, 0);
    chk("sub_y", y, 0); chk("sub_zero", zero, 1); chk("sub_ovf", ovflow, 0);
    issue(5'b01001, 32'h0, 32'h80000000, 5'd4);
    chk("sra_y", y, 64'hF8000000);
    issue(5'b01010, 32'h0, 32'h80000000, 5'd4);
    chk("srl_y", y, 64'h08000000);
    issue(5'b00010, 32'hFFFFFFFF, 32'h1, 0);
    chk("slt_y", y, 1);
    issue(5'b01000, 32'hFFFFFFFF, 32'h1, 0);
    chk("sltu_y", y, 0);

    issue(5'b00111, 32'h0, 32'h1, 5'd4);
    issue(5'b00011, 32'hF0F000FF, 32'hFF00FF00, 0);
    issue(5'b00100, 32'hF0F000FF, 32'hFF00FF00, 0);
    issue(5'b00101, 32'hF0F000FF, 32'hFF00FF00, 0);
    issue(5'b00110, 32'hF0F000FF, 32'hFF00FF00, 0);
    issue(5'b00001, 32'h80000000, 32'h1, 0);
    issue(5'b10000, 32'h80000000, 32'h0, 0);
    issue(5'b10001, 32'h0, 32'h0, 0);
    issue(5'b10010, 32'h0, 32'h0, 0);
    issue(5'b10011, 32'h80000000, 32'h0, 0);
    issue(5'b11111, 32'h12345678, 32'h1, 0);
    issue(5'b01011, 32'h12345678, 32'h1, 0);
    tick();

`ifdef ALU_MULDIV_EN
    issue(5'b00000, 32'h7FFFFFFF, 32'h1, 0);
    issue(5'b11000, 32'hFFFFFFFE, 32'd3, 0);
    repeat (W) tick();
    chk("mult_busy", busy, 1); chk("mult_early", done, 0);
    tick();
    chk("mult_done", done, 1); chk("mult_hi", hi, 64'hFFFFFFFF);
    chk("mult_lo", lo, 64'hFFFFFFFA); chk("mult_ovf_kept", ovflow, 1);
    issue(5'b11001, 32'hFFFFFFFE, 32'd3, 0);
    wait_done();
    chk("multu_hi", hi, 2); chk("multu_lo", lo, 64'hFFFFFFFA);
    issue(5'b11010, 32'hFFFFFFF9, 32'd2, 0);
    wait_done();
    chk("div_lo", lo, 64'hFFFFFFFD); chk("div_hi", hi, 64'hFFFFFFFF);
    issue(5'b11010, 32'h80000000, 32'hFFFFFFFF, 0);
    wait_done();
    chk("divmin_lo", lo, 64'h80000000); chk("divmin_hi", hi, 0); chk("divmin_dz", dz, 0);
    issue(5'b11011, 32'd7, 32'd0, 0);
    chk("dz_busy", busy, 1); chk("dz_early", done, 0);
    tick();
    chk("dz_done", done, 1); chk("dz_flag", dz, 1);
    chk("dz_lo", lo, 64'hFFFFFFFF); chk("dz_hi", hi, 7);
    tick();
    chk("dz_drop", dz, 0);
    issue(5'b11010, 32'hFFFFFFF9, 32'd0, 0);
    wait_done();
    chk("sdz_hi", hi, 64'hFFFFFFF9);
    issue(5'b11001, 32'd5, 32'd6, 0);
    repeat (3) tick();
    issue(5'b11000, 32'd7, 32'd7, 0);
    wait_done();
    chk("ign_hi", hi, 0); chk("ign_lo", lo, 30);
    tick();
    chk("ign_noqueue", busy, 0);
    issue(5'b11011, 32'd100, 32'd7, 0);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_hi", hi, 0);     chk("mrst_lo", lo, 0);
    chk("mrst_y", y, 0);       chk("mrst_zero", zero, 1);
    chk("mrst_ovf", ovflow, 0); chk("mrst_dz", dz, 0);
    tick();
    rst = 1'b0;
    issue(5'b11011, 32'd100, 32'd7, 0);
    chk("post_rst_busy", busy, 1);
    wait_done();
    chk("post_rst_lo", lo, 14); chk("post_rst_hi", hi, 2);
`else
    issue(5'b11000, 32'hFFFFFFFE, 32'd3, 0);
    chk("nomd_y", y, 0); chk("nomd_done", done, 1); chk("nomd_busy", busy, 0);
    chk("nomd_hi", hi, 0); chk("nomd_lo", lo, 0); chk("nomd_zero", zero, 1);
    issue(5'b00000, 32'd1, 32'd2, 0);
    issue(5'b11011, 32'd7, 32'd0, 0);
    chk("nomd_dz", dz, 0); chk("nomd_dz_y", y, 0); chk("nomd_dz_done", done, 1);
    rst = 1'b1;
    #1;
    chk("nrst_done", done, 0); chk("nrst_zero", zero, 1);
    tick();
    rst = 1'b0;
    issue(5'b00000, 32'd2, 32'd3, 0);
    chk("nrst_y", y, 5);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
